// File: rtl/mouse_bounds_sequencer.sv
// ---------------------------------------------------------------------------
// mouse_bounds_sequencer
//
// Purpose:
//   Programs a mouse controller with one of three cursor-bounds profiles
//   (menu, game, arena). Each accepted request produces six paced write
//   strobes: min X, min Y, max X, max Y, then the cursor is parked at the
//   centre of the box with set-X and set-Y.
//
// Ports:
//   clk                      system clock, all state changes on rising edge
//   rst                      synchronous active-high reset
//   req_menu/game/arena      one-cycle request pulses for a bounds profile
//   arena_xmin/xmax/ymin/ymax arena profile bounds, captured at grant
//   value                    12-bit data word, non-zero only with a strobe
//   setmin_x .. sety         one-cycle write strobes, at most one high
//   busy                     high from grant until the done cycle ends
//   done                     one-cycle completion pulse
//   err                      one-cycle pulse for a rejected arena profile
//   mode                     last applied profile: 0 none,1 menu,2 game,3 arena
// ---------------------------------------------------------------------------
module mouse_bounds_sequencer #(
  parameter int GAP       = 2,
  parameter int MENU_XMAX = 1019,
  parameter int MENU_YMAX = 763,
  parameter int MENU_XMIN = 0,
  parameter int MENU_YMIN = 0,
  parameter int GAME_XMAX = 800,
  parameter int GAME_YMAX = 600,
  parameter int GAME_XMIN = 400,
  parameter int GAME_YMIN = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_menu,
  input  logic        req_game,
  input  logic        req_arena,
  input  logic [11:0] arena_xmin,
  input  logic [11:0] arena_xmax,
  input  logic [11:0] arena_ymin,
  input  logic [11:0] arena_ymax,
  output logic [11:0] value,
  output logic        setmin_x,
  output logic        setmin_y,
  output logic        setmax_x,
  output logic        setmax_y,
  output logic        setx,
  output logic        sety,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  mode
);

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_GAP,
    S_DONE
  } state_t;

  // Profile codes double as the mode output encoding
  localparam logic [1:0] ProfMenu  = 2'd1;
  localparam logic [1:0] ProfGame  = 2'd2;
  localparam logic [1:0] ProfArena = 2'd3;

  // Last gap count before moving on to the next write
  localparam logic [3:0] GapLast = 4'(GAP - 1);
  localparam logic [2:0] LastIdx = 3'd5;

  state_t      state_q, state_d;
  logic [2:0]  pend_q, pend_d;        // bit0 menu, bit1 game, bit2 arena
  logic [2:0]  pend_clr;
  logic [1:0]  prof_q, prof_d;
  logic [11:0] xmin_q, xmin_d;
  logic [11:0] xmax_q, xmax_d;
  logic [11:0] ymin_q, ymin_d;
  logic [11:0] ymax_q, ymax_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  gcnt_q, gcnt_d;
  logic [11:0] value_q, value_d;
  logic [5:0]  strobe_q, strobe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  mode_q, mode_d;

  logic [11:0] xc, yc;
  logic        bounds_bad;
  logic [11:0] word;

  // Centre point uses a 13-bit sum so 4095+4095 cannot wrap before the shift
  always_comb begin
    xc = 12'((13'(xmin_q) + 13'(xmax_q)) >> 1);
    yc = 12'((13'(ymin_q) + 13'(ymax_q)) >> 1);
    bounds_bad = (xmin_q >= xmax_q) || (ymin_q >= ymax_q);
  end

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pend_q   <= 3'b000;
      prof_q   <= 2'd0;
      xmin_q   <= 12'd0;
      xmax_q   <= 12'd0;
      ymin_q   <= 12'd0;
      ymax_q   <= 12'd0;
      idx_q    <= 3'd0;
      gcnt_q   <= 4'd0;
      value_q  <= 12'd0;
      strobe_q <= 6'b000000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mode_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      prof_q   <= prof_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      ymax_q   <= ymax_d;
      idx_q    <= idx_d;
      gcnt_q   <= gcnt_d;
      value_q  <= value_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mode_q   <= mode_d;
    end
  end

  // Next-state logic. The bounds are captured on the IDLE->LOAD edge so
  // later changes on the arena inputs cannot leak into a running sequence.
  always_comb begin
    state_d  = state_q;
    prof_d   = prof_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    ymin_d   = ymin_q;
    ymax_d   = ymax_q;
    idx_d    = idx_q;
    gcnt_d   = gcnt_q;
    mode_d   = mode_q;
    err_d    = 1'b0;
    done_d   = 1'b0;
    pend_clr = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          state_d = S_LOAD;
          // Priority: game, then arena, then menu
          if (pend_q[1]) begin
            pend_clr = 3'b010;
            prof_d   = ProfGame;
            xmin_d   = 12'(GAME_XMIN);
            xmax_d   = 12'(GAME_XMAX);
            ymin_d   = 12'(GAME_YMIN);
            ymax_d   = 12'(GAME_YMAX);
          end else if (pend_q[2]) begin
            pend_clr = 3'b100;
            prof_d   = ProfArena;
            xmin_d   = arena_xmin;
            xmax_d   = arena_xmax;
            ymin_d   = arena_ymin;
            ymax_d   = arena_ymax;
          end else begin
            pend_clr = 3'b001;
            prof_d   = ProfMenu;
            xmin_d   = 12'(MENU_XMIN);
            xmax_d   = 12'(MENU_XMAX);
            ymin_d   = 12'(MENU_YMIN);
            ymax_d   = 12'(MENU_YMAX);
          end
        end
      end

      S_LOAD: begin
        idx_d  = 3'd0;
        gcnt_d = 4'd0;
        // Only the arena profile comes from outside and can be malformed
        if ((prof_q == ProfArena) && bounds_bad) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (idx_q == LastIdx) begin
          state_d = S_DONE;
        end else if (GAP == 0) begin
          idx_d   = idx_q + 3'd1;
          state_d = S_WRITE;
        end else begin
          gcnt_d  = 4'd0;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (gcnt_q == GapLast) begin
          idx_d   = idx_q + 3'd1;
          state_d = S_WRITE;
        end else begin
          gcnt_d  = gcnt_q + 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A request on the grant edge re-arms its bit; otherwise requests coalesce
    pend_d = (pend_q & ~pend_clr) | {req_arena, req_game, req_menu};

    // Done and mode are set on the edge that enters DONE
    if (state_d == S_DONE) begin
      done_d = 1'b1;
      mode_d = prof_q;
    end
  end

  // Data word selected by the upcoming write index
  always_comb begin
    case (idx_d)
      3'd0:    word = xmin_q;
      3'd1:    word = ymin_q;
      3'd2:    word = xmax_q;
      3'd3:    word = ymax_q;
      3'd4:    word = xc;
      3'd5:    word = yc;
      default: word = 12'd0;
    endcase
  end

  // Output registers are loaded from the next state so strobe, value and
  // busy line up exactly with the state they describe.
  always_comb begin
    strobe_d = 6'b000000;
    value_d  = 12'd0;
    busy_d   = (state_d != S_IDLE);
    if (state_d == S_WRITE) begin
      strobe_d = 6'(6'b000001 << idx_d);
      value_d  = word;
    end
  end

  assign value    = value_q;
  assign setmin_x = strobe_q[0];
  assign setmin_y = strobe_q[1];
  assign setmax_x = strobe_q[2];
  assign setmax_y = strobe_q[3];
  assign setx     = strobe_q[4];
  assign sety     = strobe_q[5];
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mode     = mode_q;

endmodule

// File: tb/tb_mouse_bounds_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mouse_bounds_sequencer
//
// Purpose:
//   Directed self-checking bench for mouse_bounds_sequencer with GAP=2.
//   A negedge monitor logs every strobe (index, value, cycle) and counts
//   busy/done/err cycles; the main initial block checks those logs.
// ---------------------------------------------------------------------------
module tb_mouse_bounds_sequencer;

  localparam int GAP = 2;
  localparam int BUSY_LEN = 1 + 6 + 5 * GAP + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqMenu = 1'b0;
  logic        reqGame = 1'b0;
  logic        reqArena = 1'b0;
  logic [11:0] arenaXmin = 12'd0;
  logic [11:0] arenaXmax = 12'd0;
  logic [11:0] arenaYmin = 12'd0;
  logic [11:0] arenaYmax = 12'd0;
  logic [11:0] value;
  logic        setminX, setminY, setmaxX, setmaxY, setX, setY;
  logic        busy, done, err;
  logic [1:0]  mode;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } strobeEvent_t;

  strobeEvent_t evq[$];
  logic [5:0]   strobes;
  int cyc = 0;
  int busyCycles = 0;
  int doneCount = 0;
  int errCount = 0;
  int multiStrobe = 0;
  int valueLeak = 0;
  int testsRun = 0;
  int failCount = 0;
  int reqEdgeCyc = 0;
  int done0, err0, busy0;

  mouse_bounds_sequencer #(.GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_menu   (reqMenu),
    .req_game   (reqGame),
    .req_arena  (reqArena),
    .arena_xmin (arenaXmin),
    .arena_xmax (arenaXmax),
    .arena_ymin (arenaYmin),
    .arena_ymax (arenaYmax),
    .value      (value),
    .setmin_x   (setminX),
    .setmin_y   (setminY),
    .setmax_x   (setmaxX),
    .setmax_y   (setmaxY),
    .setx       (setX),
    .sety       (setY),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mode       (mode)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Cycle counter, advanced on each active edge
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor sampling on the inactive edge: logs strobes and counts pulses
  always @(negedge clk) begin
    strobes = {setY, setX, setmaxY, setmaxX, setminY, setminX};
    if ($countones(strobes) > 1) begin
      multiStrobe++;
    end else if ($countones(strobes) == 1) begin
      for (int k = 0; k < 6; k++) begin
        if (strobes[k]) evq.push_back('{k, int'(value), cyc});
      end
    end else if (value !== 12'd0) begin
      valueLeak++;
    end
    if (busy === 1'b1) busyCycles++;
    if (done === 1'b1) doneCount++;
    if (err === 1'b1) errCount++;
  end

  // One comparison: counts it, and on mismatch counts and reports the failure
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Pulses the selected request lines for one cycle; records the edge cycle
  task automatic applyStimulus(input logic m, input logic g, input logic a);
    @(negedge clk);
    reqMenu  = m;
    reqGame  = g;
    reqArena = a;
    @(posedge clk);
    #1;
    reqEdgeCyc = cyc;
    reqMenu  = 1'b0;
    reqGame  = 1'b0;
    reqArena = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Pops six logged strobes and checks order, values and spacing
  task automatic checkSequence(input string tag, input int v0, input int v1,
                               input int v2, input int v3, input int v4,
                               input int v5, input int firstCyc);
    int expVal[6];
    int prevCyc;
    strobeEvent_t ev;
    expVal = '{v0, v1, v2, v3, v4, v5};
    prevCyc = 0;
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("%s_present%0d", tag, i), 32'(evq.size() != 0), 32'd1);
      if (evq.size() != 0) begin
        ev = evq.pop_front();
        checkOutput($sformatf("%s_kind%0d", tag, i), ev.kind, i);
        checkOutput($sformatf("%s_value%0d", tag, i), ev.val, expVal[i]);
        if (i == 0) begin
          if (firstCyc >= 0) checkOutput($sformatf("%s_latency", tag), ev.cyc, firstCyc);
        end else begin
          checkOutput($sformatf("%s_spacing%0d", tag, i), ev.cyc - prevCyc, GAP + 1);
        end
        prevCyc = ev.cyc;
      end
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    runCycles(3);
    checkOutput("reset_value", value, 0);
    checkOutput("reset_strobes", {setY, setX, setmaxY, setmaxX, setminY, setminX}, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_mode", mode, 0);
    @(negedge clk);
    rst = 1'b0;
    runCycles(2);
    evq.delete();

    // Game profile
    done0 = doneCount; busy0 = busyCycles;
    applyStimulus(1'b0, 1'b1, 1'b0);
    runCycles(30);
    checkSequence("game", 400, 200, 800, 600, 600, 400, reqEdgeCyc + 2);
    checkOutput("game_extra", evq.size(), 0);
    checkOutput("game_done", doneCount - done0, 1);
    checkOutput("game_mode", mode, 2);
    checkOutput("game_busy_len", busyCycles - busy0, BUSY_LEN);
    checkOutput("game_busy_end", busy, 0);

    // Menu profile
    evq.delete();
    done0 = doneCount; busy0 = busyCycles;
    applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(30);
    checkSequence("menu", 0, 0, 1019, 763, 509, 381, reqEdgeCyc + 2);
    checkOutput("menu_done", doneCount - done0, 1);
    checkOutput("menu_mode", mode, 1);
    checkOutput("menu_busy_len", busyCycles - busy0, BUSY_LEN);

    // Simultaneous menu and game: game first, then menu
    evq.delete();
    done0 = doneCount;
    applyStimulus(1'b1, 1'b1, 1'b0);
    runCycles(60);
    checkSequence("both_game", 400, 200, 800, 600, 600, 400, reqEdgeCyc + 2);
    checkSequence("both_menu", 0, 0, 1019, 763, 509, 381, -1);
    checkOutput("both_done", doneCount - done0, 2);
    checkOutput("both_mode", mode, 1);

    // Invalid arena: xmin == xmax
    evq.delete();
    done0 = doneCount; err0 = errCount; busy0 = busyCycles;
    arenaXmin = 12'd500; arenaXmax = 12'd500;
    arenaYmin = 12'd10;  arenaYmax = 12'd20;
    applyStimulus(1'b0, 1'b0, 1'b1);
    runCycles(15);
    checkOutput("bad_arena_strobes", evq.size(), 0);
    checkOutput("bad_arena_err", errCount - err0, 1);
    checkOutput("bad_arena_done", doneCount - done0, 0);
    checkOutput("bad_arena_mode", mode, 1);
    checkOutput("bad_arena_busy_len", busyCycles - busy0, 1);

    // Valid arena; inputs scrambled once the grant has captured them
    evq.delete();
    done0 = doneCount;
    arenaXmin = 12'd100; arenaXmax = 12'd4095;
    arenaYmin = 12'd50;  arenaYmax = 12'd4000;
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    arenaXmin = 12'd3000; arenaXmax = 12'd7;
    arenaYmin = 12'd2222; arenaYmax = 12'd9;
    runCycles(30);
    checkSequence("arena", 100, 50, 4095, 4000, 2097, 2025, reqEdgeCyc + 2);
    checkOutput("arena_done", doneCount - done0, 1);
    checkOutput("arena_mode", mode, 3);

    // Reset after the third strobe of a game sequence
    evq.delete();
    done0 = doneCount;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40 && evq.size() < 3; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("rst_third_seen", evq.size(), 3);
    rst = 1'b1;
    reqMenu = 1'b1;
    @(posedge clk);
    #1;
    reqMenu = 1'b0;
    runCycles(1);
    checkOutput("rst_busy_during", busy, 0);
    reqGame = 1'b1;
    @(posedge clk);
    #1;
    reqGame = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    runCycles(30);
    checkOutput("rst_strobe_total", evq.size(), 3);
    if (evq.size() >= 3) checkOutput("rst_third_value", evq[2].val, 800);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mode", mode, 0);
    checkOutput("rst_no_done", doneCount - done0, 0);

    // Requests work again after release
    evq.delete();
    applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(30);
    checkSequence("post_rst_menu", 0, 0, 1019, 763, 509, 381, reqEdgeCyc + 2);
    checkOutput("post_rst_mode", mode, 1);

    // Run-wide invariants
    checkOutput("multi_strobe", multiStrobe, 0);
    checkOutput("value_leak", valueLeak, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
